// File: rtl/sync_fifo_preload.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_preload
// Description : Single-clock FIFO whose storage is filled after reset (and on
//               request) with the arithmetic sequence
//               INIT_BASE + k*INIT_STEP, k = 0..DEPTH-1 (mod 2^WIDTH). It is
//               used as the free-address pool for the switch buffer manager.
//               It provides an occupancy count, registered full/empty and
//               programmable almost-full/almost-empty flags, and one-cycle
//               error pulses for rejected requests.
//
// Build option: FIFO_PRELOAD_EN
//               defined   - the INIT fill engine is built. Reset or
//                           fifo_reinit refills all DEPTH entries over
//                           DEPTH cycles.
//               undefined - no fill engine. Reset and fifo_reinit leave the
//                           FIFO empty, and fifo_init_done rises on the first
//                           clock edge after reset release.
//
// Parameters  : WIDTH      data width (WIDTH >= log2(DEPTH))
//               DEPTH      entries, power of 2, 4..1024
//               INIT_BASE  first preloaded value
//               INIT_STEP  increment between preloaded values
//               AFULL_TH   fifo_afull  when count >= AFULL_TH
//               AEMPTY_TH  fifo_aempty when count <= AEMPTY_TH
//
// Ports       : clk            in   clock
//               rst_n          in   asynchronous active-low reset
//               fifo_reinit    in   restart initialisation (honoured in RUN)
//               fifo_wr_en     in   write request
//               fifo_wr_data   in   write data [WIDTH]
//               fifo_rd_en     in   read request
//               fifo_rd_data   out  registered read data [WIDTH], 1-cycle latency
//               fifo_full      out  count == DEPTH
//               fifo_empty     out  count == 0
//               fifo_afull     out  almost full
//               fifo_aempty    out  almost empty
//               fifo_count     out  occupancy [log2(DEPTH)+1]
//               fifo_init_done out  high in RUN state
//               fifo_wr_err    out  one-cycle pulse per rejected write
//               fifo_rd_err    out  one-cycle pulse per rejected read
//
// Revision    : 1.0  initial release
// ============================================================================
module sync_fifo_preload #(
    parameter int WIDTH     = 6,
    parameter int DEPTH     = 32,
    parameter int INIT_BASE = 0,
    parameter int INIT_STEP = 1,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fifo_reinit,
    input  logic                     fifo_wr_en,
    input  logic [WIDTH-1:0]         fifo_wr_data,
    input  logic                     fifo_rd_en,
    output logic [WIDTH-1:0]         fifo_rd_data,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic                     fifo_afull,
    output logic                     fifo_aempty,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     fifo_init_done,
    output logic                     fifo_wr_err,
    output logic                     fifo_rd_err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_AW = $clog2(DEPTH);   // pointer width
    localparam int c_CW = c_AW + 1;        // count width (must hold DEPTH)

    localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_AFULL_TH  = c_CW'(AFULL_TH);
    localparam logic [c_CW-1:0] c_AEMPTY_TH = c_CW'(AEMPTY_TH);

    // In the build without the fill engine the reset state is held for only
    // one cycle and performs no writes; it exists so that fifo_init_done
    // rises on the first edge after reset release.
    localparam logic [0:0] c_ST_INIT = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

`ifdef FIFO_PRELOAD_EN
    localparam logic [c_AW-1:0]  c_LAST_IDX  = c_AW'(DEPTH - 1);
    localparam logic [WIDTH-1:0] c_INIT_BASE = WIDTH'(INIT_BASE);
    localparam logic [WIDTH-1:0] c_INIT_STEP = WIDTH'(INIT_STEP);
`else
    // The preload values have no meaning in this build; fold them into a
    // dangling signal so the parameters remain referenced.
    logic w_unused_init;
    assign w_unused_init = ^{WIDTH'(INIT_BASE), WIDTH'(INIT_STEP)};
`endif

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]        r_state;
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_count;
    logic [WIDTH-1:0]  r_rd_data;
    logic              r_full;
    logic              r_empty;
    logic              r_afull;
    logic              r_aempty;
    logic              r_wr_err;
    logic              r_rd_err;

    // Storage array; intentionally not reset.
    logic [WIDTH-1:0]  r_mem [DEPTH];

`ifdef FIFO_PRELOAD_EN
    logic [c_AW-1:0]   r_init_idx;
    logic [WIDTH-1:0]  r_init_val;   // running INIT_BASE + idx*INIT_STEP
    logic [c_AW-1:0]   w_init_idx_nxt;
    logic [WIDTH-1:0]  w_init_val_nxt;
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    logic [0:0]        w_state_nxt;
    logic [c_AW-1:0]   w_wr_ptr_nxt;
    logic [c_AW-1:0]   w_rd_ptr_nxt;
    logic [c_CW-1:0]   w_count_nxt;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic              w_wr_err_nxt;
    logic              w_rd_err_nxt;
    logic              w_mem_we;
    logic [WIDTH-1:0]  w_mem_wdata;

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        w_rd_acc     = 1'b0;
        w_wr_acc     = 1'b0;
        w_wr_err_nxt = 1'b0;
        w_rd_err_nxt = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_wdata  = fifo_wr_data;
`ifdef FIFO_PRELOAD_EN
        w_init_idx_nxt = r_init_idx;
        w_init_val_nxt = r_init_val;
`endif

        if (r_state == c_ST_INIT) begin
            // Requests are never served before RUN; each one is flagged.
            // fifo_reinit has no effect here.
            w_wr_err_nxt = fifo_wr_en;
            w_rd_err_nxt = fifo_rd_en;
`ifdef FIFO_PRELOAD_EN
            // The fill writes through the normal write pointer, so after the
            // last entry wr_ptr has wrapped back to 0 and count == DEPTH.
            w_mem_we       = 1'b1;
            w_mem_wdata    = r_init_val;
            w_wr_ptr_nxt   = r_wr_ptr + 1'b1;
            w_count_nxt    = r_count + 1'b1;
            w_init_idx_nxt = r_init_idx + 1'b1;
            w_init_val_nxt = r_init_val + c_INIT_STEP;
            if (r_init_idx == c_LAST_IDX) begin
                w_state_nxt = c_ST_RUN;
            end
`else
            w_state_nxt = c_ST_RUN;
`endif
        end else if (fifo_reinit) begin
            // Concurrent read/write requests are dropped silently.
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_count_nxt  = '0;
`ifdef FIFO_PRELOAD_EN
            w_state_nxt    = c_ST_INIT;
            w_init_idx_nxt = '0;
            w_init_val_nxt = c_INIT_BASE;
`endif
        end else begin
            // A write into a full FIFO is allowed when a read frees a slot in
            // the same cycle. A write into an empty FIFO is not bypassed to a
            // concurrent read; the read is rejected.
            w_rd_acc     = fifo_rd_en && (r_count != '0);
            w_wr_acc     = fifo_wr_en && ((r_count != c_DEPTH_CNT) || w_rd_acc);
            w_rd_err_nxt = fifo_rd_en && !w_rd_acc;
            w_wr_err_nxt = fifo_wr_en && !w_wr_acc;

            if (w_rd_acc) begin
                w_rd_ptr_nxt = r_rd_ptr + 1'b1;
            end
            if (w_wr_acc) begin
                w_mem_we     = 1'b1;
                w_wr_ptr_nxt = r_wr_ptr + 1'b1;
            end

            case ({w_wr_acc, w_rd_acc})
                2'b10:   w_count_nxt = r_count + 1'b1;
                2'b01:   w_count_nxt = r_count - 1'b1;
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_INIT;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rd_data <= '0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_afull   <= 1'b0;
            r_aempty  <= 1'b1;
            r_wr_err  <= 1'b0;
            r_rd_err  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_wr_err <= w_wr_err_nxt;
            r_rd_err <= w_rd_err_nxt;

            // Read data holds until the next accepted read.
            if (w_rd_acc) begin
                r_rd_data <= r_mem[r_rd_ptr];
            end

            // Flags come from the next count so they line up with fifo_count.
            r_full   <= (w_count_nxt == c_DEPTH_CNT);
            r_empty  <= (w_count_nxt == '0);
            r_afull  <= (w_count_nxt >= c_AFULL_TH);
            r_aempty <= (w_count_nxt <= c_AEMPTY_TH);
        end
    end

`ifdef FIFO_PRELOAD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init_idx <= '0;
            r_init_val <= c_INIT_BASE;
        end else begin
            r_init_idx <= w_init_idx_nxt;
            r_init_val <= w_init_val_nxt;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_wr_ptr] <= w_mem_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign fifo_rd_data   = r_rd_data;
    assign fifo_full      = r_full;
    assign fifo_empty     = r_empty;
    assign fifo_afull     = r_afull;
    assign fifo_aempty    = r_aempty;
    assign fifo_count     = r_count;
    assign fifo_init_done = (r_state == c_ST_RUN);
    assign fifo_wr_err    = r_wr_err;
    assign fifo_rd_err    = r_rd_err;

endmodule

`default_nettype wire
